// File: rtl/rv32_pkg.sv
// Shared types for the RV32 pipeline sequencer: FSM state encoding and the
// EX operand-source select codes.
package rv32_pkg;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_HALTED = 2'd2
  } hz_state_t;

  localparam logic [1:0] FWD_RF    = 2'b00;
  localparam logic [1:0] FWD_EXMEM = 2'b01;
  localparam logic [1:0] FWD_MEMWB = 2'b10;

endpackage

// File: rtl/rv32_hazard_ctrl_if.sv
// Bundle between the pipeline datapath (master) and the hazard sequencer (slave):
// decoded register usage and stage status in, holds/flushes/forward selects out.
interface rv32_hazard_ctrl_if #(
  parameter int CNT_W = 16
);
  logic             id_valid;
  logic [4:0]       id_rs1;
  logic [4:0]       id_rs2;
  logic             id_halt;
  logic             ex_valid;
  logic [4:0]       ex_rd;
  logic             ex_write_reg;
  logic             ex_load;
  logic             ex_redirect;
  logic             mem_valid;
  logic [4:0]       mem_rd;
  logic             mem_write_reg;
  logic             mem_req;
  logic             mem_ready;

  logic             pc_hold;
  logic             ifid_hold;
  logic             ifid_flush;
  logic             idex_bubble;
  logic             exmem_hold;
  logic [1:0]       fwd_a;
  logic [1:0]       fwd_b;
  logic             halted;
  logic             err_timeout;
  logic [CNT_W-1:0] stall_cnt;

  modport master (
    output id_valid, id_rs1, id_rs2, id_halt,
    output ex_valid, ex_rd, ex_write_reg, ex_load, ex_redirect,
    output mem_valid, mem_rd, mem_write_reg, mem_req, mem_ready,
    input  pc_hold, ifid_hold, ifid_flush, idex_bubble, exmem_hold,
    input  fwd_a, fwd_b, halted, err_timeout, stall_cnt
  );

  modport slave (
    input  id_valid, id_rs1, id_rs2, id_halt,
    input  ex_valid, ex_rd, ex_write_reg, ex_load, ex_redirect,
    input  mem_valid, mem_rd, mem_write_reg, mem_req, mem_ready,
    output pc_hold, ifid_hold, ifid_flush, idex_bubble, exmem_hold,
    output fwd_a, fwd_b, halted, err_timeout, stall_cnt
  );
endinterface

// File: rtl/rv32_fwd_sel.sv
// Per-operand forwarding select: the youngest in-flight writer of rs wins,
// x0 is never forwarded.
module rv32_fwd_sel
  import rv32_pkg::*;
(
  input  logic [4:0] rs,
  input  logic       ex_valid,
  input  logic       ex_write_reg,
  input  logic [4:0] ex_rd,
  input  logic       mem_valid,
  input  logic       mem_write_reg,
  input  logic [4:0] mem_rd,
  output logic [1:0] sel
);

  always_comb begin
    sel = FWD_RF;
    if (rs != 5'd0 && ex_valid && ex_write_reg && ex_rd == rs) begin
      sel = FWD_EXMEM;
    end else if (rs != 5'd0 && mem_valid && mem_write_reg && mem_rd == rs) begin
      sel = FWD_MEMWB;
    end
  end

endmodule

// File: rtl/rv32_hazard_ctrl.sv
// 5-stage RV32 pipeline sequencer: stall/flush/bubble generation, registered
// operand-forward selects, and the drain-then-halt FSM.
module rv32_hazard_ctrl
  import rv32_pkg::*;
#(
  parameter int DRAIN_CYCLES = 3,
  parameter int MEM_TIMEOUT  = 255,
  parameter int CNT_W        = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  rv32_hazard_ctrl_if.slave  hz
);

  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
  localparam int DC_W   = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  hz_state_t        state_reg;
  logic [DC_W-1:0]  drain_cnt_reg;
  logic [WAIT_W-1:0] wait_cnt_reg;
  logic [1:0]       fwd_a_reg;
  logic [1:0]       fwd_b_reg;
  logic             halted_reg;
  logic             err_timeout_reg;
  logic [CNT_W-1:0] stall_cnt_reg;

  logic memwait;
  logic redirect;
  logic load_use;
  logic halt_go;
  logic pc_hold;
  logic ifid_hold;
  logic ifid_flush;
  logic idex_bubble;
  logic exmem_hold;

  logic [4:0] rs_arr  [2];
  logic [1:0] sel_arr [2];

  assign rs_arr[0] = hz.id_rs1;
  assign rs_arr[1] = hz.id_rs2;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_fwd
      rv32_fwd_sel u_sel (
        .rs            (rs_arr[gi]),
        .ex_valid      (hz.ex_valid),
        .ex_write_reg  (hz.ex_write_reg),
        .ex_rd         (hz.ex_rd),
        .mem_valid     (hz.mem_valid),
        .mem_write_reg (hz.mem_write_reg),
        .mem_rd        (hz.mem_rd),
        .sel           (sel_arr[gi])
      );
    end
  endgenerate

  assign memwait  = hz.mem_req & ~hz.mem_ready;
  assign redirect = hz.ex_redirect & hz.ex_valid & (state_reg != ST_HALTED);
  assign load_use = hz.id_valid & hz.ex_valid & hz.ex_load & hz.ex_write_reg &
                    (hz.ex_rd != 5'd0) &
                    ((hz.id_rs1 == hz.ex_rd) | (hz.id_rs2 == hz.ex_rd));
  assign halt_go  = (state_reg == ST_RUN) & hz.id_valid & hz.id_halt & ~load_use;

  // Holds act in the same cycle; memory wait freezes everything, a halted core
  // ignores redirects, and a redirect overrides draining and load-use stalls.
  always_comb begin
    pc_hold     = 1'b0;
    ifid_hold   = 1'b0;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    exmem_hold  = 1'b0;
    if (memwait) begin
      pc_hold    = 1'b1;
      ifid_hold  = 1'b1;
      exmem_hold = 1'b1;
    end else if (redirect) begin
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
    end else if (state_reg != ST_RUN || load_use || halt_go) begin
      pc_hold     = 1'b1;
      ifid_hold   = 1'b1;
      idex_bubble = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg       <= ST_RUN;
      drain_cnt_reg   <= '0;
      wait_cnt_reg    <= '0;
      fwd_a_reg       <= FWD_RF;
      fwd_b_reg       <= FWD_RF;
      halted_reg      <= 1'b0;
      err_timeout_reg <= 1'b0;
      stall_cnt_reg   <= '0;
    end else begin
      halted_reg <= (state_reg == ST_HALTED);
      if (pc_hold && stall_cnt_reg != '1) begin
        stall_cnt_reg <= stall_cnt_reg + 1'b1;
      end
      if (memwait) begin
        if (wait_cnt_reg == WAIT_W'(MEM_TIMEOUT)) begin
          err_timeout_reg <= 1'b1;
        end else begin
          wait_cnt_reg <= wait_cnt_reg + 1'b1;
        end
      end else begin
        wait_cnt_reg <= '0;
        // Forward selects follow ID into EX only when ID/EX advances.
        if (idex_bubble || !hz.id_valid) begin
          fwd_a_reg <= FWD_RF;
          fwd_b_reg <= FWD_RF;
        end else begin
          fwd_a_reg <= sel_arr[0];
          fwd_b_reg <= sel_arr[1];
        end
        if (redirect) begin
          state_reg     <= ST_RUN;
          drain_cnt_reg <= '0;
        end else begin
          case (state_reg)
            ST_RUN: begin
              if (halt_go) begin
                state_reg     <= ST_DRAIN;
                drain_cnt_reg <= DC_W'(DRAIN_CYCLES - 1);
              end
            end
            ST_DRAIN: begin
              if (drain_cnt_reg == '0) begin
                state_reg <= ST_HALTED;
              end else begin
                drain_cnt_reg <= drain_cnt_reg - 1'b1;
              end
            end
            default: state_reg <= ST_HALTED;
          endcase
        end
      end
    end
  end

  assign hz.pc_hold     = pc_hold;
  assign hz.ifid_hold   = ifid_hold;
  assign hz.ifid_flush  = ifid_flush;
  assign hz.idex_bubble = idex_bubble;
  assign hz.exmem_hold  = exmem_hold;
  assign hz.fwd_a       = fwd_a_reg;
  assign hz.fwd_b       = fwd_b_reg;
  assign hz.halted      = halted_reg;
  assign hz.err_timeout = err_timeout_reg;
  assign hz.stall_cnt   = stall_cnt_reg;

endmodule

// File: tb/tb_rv32_hazard_ctrl.sv
// Directed bench for rv32_hazard_ctrl: load-use, forwarding priority, redirect,
// memory wait/timeout, drain-then-halt and stall counter saturation.
module tb_rv32_hazard_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  rv32_hazard_ctrl_if #(.CNT_W(16)) hc ();
  rv32_hazard_ctrl_if #(.CNT_W(3))  hc2 ();

  rv32_hazard_ctrl #(.DRAIN_CYCLES(3), .MEM_TIMEOUT(3), .CNT_W(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .hz    (hc)
  );

  rv32_hazard_ctrl #(.DRAIN_CYCLES(3), .MEM_TIMEOUT(3), .CNT_W(3)) dut_sat (
    .clk   (clk),
    .rst_n (rst_n),
    .hz    (hc2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    hc.id_valid = 0; hc.id_rs1 = 0; hc.id_rs2 = 0; hc.id_halt = 0;
    hc.ex_valid = 0; hc.ex_rd = 0; hc.ex_write_reg = 0; hc.ex_load = 0; hc.ex_redirect = 0;
    hc.mem_valid = 0; hc.mem_rd = 0; hc.mem_write_reg = 0; hc.mem_req = 0; hc.mem_ready = 1;
  endtask

  task automatic idle2();
    hc2.id_valid = 0; hc2.id_rs1 = 0; hc2.id_rs2 = 0; hc2.id_halt = 0;
    hc2.ex_valid = 0; hc2.ex_rd = 0; hc2.ex_write_reg = 0; hc2.ex_load = 0; hc2.ex_redirect = 0;
    hc2.mem_valid = 0; hc2.mem_rd = 0; hc2.mem_write_reg = 0; hc2.mem_req = 0; hc2.mem_ready = 1;
  endtask

  task automatic do_reset();
    idle();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    n_tests++; if (hc.fwd_a !== 2'b00) begin n_fail++; $display("FAIL reset_fwd_a: got %b want 00", hc.fwd_a); end
    n_tests++; if (hc.fwd_b !== 2'b00) begin n_fail++; $display("FAIL reset_fwd_b: got %b want 00", hc.fwd_b); end
    n_tests++; if (hc.halted !== 1'b0) begin n_fail++; $display("FAIL reset_halted: got %b want 0", hc.halted); end
    n_tests++; if (hc.err_timeout !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", hc.err_timeout); end
    n_tests++; if (hc.stall_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_stall_cnt: got %0d want 0", hc.stall_cnt); end
    n_tests++; if (hc.pc_hold !== 1'b0) begin n_fail++; $display("FAIL reset_pc_hold: got %b want 0", hc.pc_hold); end
    $display("[TB] reset: fwd_a=%b fwd_b=%b halted=%b stall_cnt=%0d", hc.fwd_a, hc.fwd_b, hc.halted, hc.stall_cnt);
  endtask

  task automatic test_load_use();
    do_reset();
    hc.id_valid = 1; hc.id_rs1 = 5; hc.ex_valid = 1; hc.ex_load = 1; hc.ex_write_reg = 1; hc.ex_rd = 5;
    #1;
    n_tests++; if ({hc.pc_hold, hc.ifid_hold, hc.idex_bubble} !== 3'b111) begin n_fail++; $display("FAIL lu_holds: got %b want 111", {hc.pc_hold, hc.ifid_hold, hc.idex_bubble}); end
    n_tests++; if ({hc.ifid_flush, hc.exmem_hold} !== 2'b00) begin n_fail++; $display("FAIL lu_flush_exmem: got %b want 00", {hc.ifid_flush, hc.exmem_hold}); end
    tick();
    n_tests++; if (hc.fwd_a !== 2'b00) begin n_fail++; $display("FAIL lu_fwd_bubble: got %b want 00", hc.fwd_a); end
    n_tests++; if (hc.stall_cnt !== 16'd1) begin n_fail++; $display("FAIL lu_stall_cnt: got %0d want 1", hc.stall_cnt); end
    hc.ex_valid = 0; hc.ex_load = 0; hc.ex_write_reg = 0; hc.mem_valid = 1; hc.mem_rd = 5; hc.mem_write_reg = 1;
    #1;
    n_tests++; if (hc.pc_hold !== 1'b0) begin n_fail++; $display("FAIL lu_release: got %b want 0", hc.pc_hold); end
    tick();
    n_tests++; if (hc.fwd_a !== 2'b10) begin n_fail++; $display("FAIL lu_fwd_memwb: got %b want 10", hc.fwd_a); end
    n_tests++; if (hc.stall_cnt !== 16'd1) begin n_fail++; $display("FAIL lu_stall_cnt2: got %0d want 1", hc.stall_cnt); end
    $display("[TB] load_use: fwd_a=%b stall_cnt=%0d", hc.fwd_a, hc.stall_cnt);
  endtask

  task automatic test_fwd_priority();
    do_reset();
    hc.id_valid = 1; hc.id_rs1 = 0; hc.id_rs2 = 7;
    hc.ex_valid = 1; hc.ex_write_reg = 1; hc.ex_rd = 7;
    hc.mem_valid = 1; hc.mem_write_reg = 1; hc.mem_rd = 7;
    tick();
    n_tests++; if (hc.fwd_b !== 2'b01) begin n_fail++; $display("FAIL fwd_ex_wins: got %b want 01", hc.fwd_b); end
    n_tests++; if (hc.fwd_a !== 2'b00) begin n_fail++; $display("FAIL fwd_x0: got %b want 00", hc.fwd_a); end
    hc.ex_rd = 0; hc.mem_rd = 0;
    tick();
    n_tests++; if (hc.fwd_a !== 2'b00) begin n_fail++; $display("FAIL fwd_x0_both: got %b want 00", hc.fwd_a); end
    hc.id_rs1 = 3; hc.ex_rd = 3; hc.ex_write_reg = 0; hc.mem_rd = 3;
    tick();
    n_tests++; if (hc.fwd_a !== 2'b10) begin n_fail++; $display("FAIL fwd_ex_nowrite: got %b want 10", hc.fwd_a); end
    hc.ex_write_reg = 1; hc.id_valid = 0;
    tick();
    n_tests++; if (hc.fwd_a !== 2'b00) begin n_fail++; $display("FAIL fwd_id_invalid: got %b want 00", hc.fwd_a); end
    $display("[TB] fwd_priority: fwd_a=%b fwd_b=%b", hc.fwd_a, hc.fwd_b);
  endtask

  task automatic test_redirect_vs_load_use();
    do_reset();
    hc.id_valid = 1; hc.id_rs1 = 5; hc.ex_valid = 1; hc.ex_load = 1; hc.ex_write_reg = 1; hc.ex_rd = 5;
    hc.ex_redirect = 1;
    #1;
    n_tests++; if ({hc.ifid_flush, hc.idex_bubble} !== 2'b11) begin n_fail++; $display("FAIL rd_flush_bubble: got %b want 11", {hc.ifid_flush, hc.idex_bubble}); end
    n_tests++; if ({hc.pc_hold, hc.ifid_hold} !== 2'b00) begin n_fail++; $display("FAIL rd_no_hold: got %b want 00", {hc.pc_hold, hc.ifid_hold}); end
    tick();
    $display("[TB] redirect_vs_load_use: flush applied, stall_cnt=%0d", hc.stall_cnt);
  endtask

  task automatic test_memwait();
    do_reset();
    hc.id_valid = 1; hc.id_rs2 = 7; hc.ex_valid = 1; hc.ex_write_reg = 1; hc.ex_rd = 7;
    tick();
    n_tests++; if (hc.fwd_b !== 2'b01) begin n_fail++; $display("FAIL mw_setup_fwd: got %b want 01", hc.fwd_b); end
    hc.ex_load = 1; hc.mem_req = 1; hc.mem_ready = 0;
    for (int i = 1; i <= 4; i++) begin
      #1;
      n_tests++; if ({hc.pc_hold, hc.ifid_hold, hc.exmem_hold, hc.idex_bubble} !== 4'b1110) begin n_fail++; $display("FAIL mw_holds c%0d: got %b want 1110", i, {hc.pc_hold, hc.ifid_hold, hc.exmem_hold, hc.idex_bubble}); end
      tick();
      n_tests++; if (hc.err_timeout !== (i == 4)) begin n_fail++; $display("FAIL mw_err c%0d: got %b want %b", i, hc.err_timeout, (i == 4)); end
    end
    n_tests++; if (hc.fwd_b !== 2'b01) begin n_fail++; $display("FAIL mw_fwd_frozen: got %b want 01", hc.fwd_b); end
    n_tests++; if (hc.stall_cnt !== 16'd4) begin n_fail++; $display("FAIL mw_stall_cnt: got %0d want 4", hc.stall_cnt); end
    hc.mem_ready = 1;
    #1;
    n_tests++; if ({hc.idex_bubble, hc.exmem_hold} !== 2'b10) begin n_fail++; $display("FAIL mw_lu_after: got %b want 10", {hc.idex_bubble, hc.exmem_hold}); end
    tick();
    n_tests++; if (hc.fwd_b !== 2'b00) begin n_fail++; $display("FAIL mw_fwd_bubble: got %b want 00", hc.fwd_b); end
    n_tests++; if (hc.stall_cnt !== 16'd5) begin n_fail++; $display("FAIL mw_stall_cnt2: got %0d want 5", hc.stall_cnt); end
    idle();
    tick(); tick();
    n_tests++; if (hc.err_timeout !== 1'b1) begin n_fail++; $display("FAIL mw_err_sticky: got %b want 1", hc.err_timeout); end
    $display("[TB] memwait: err_timeout=%b stall_cnt=%0d", hc.err_timeout, hc.stall_cnt);
  endtask

  task automatic test_halt();
    do_reset();
    hc.id_valid = 1; hc.id_halt = 1;
    #1;
    n_tests++; if ({hc.pc_hold, hc.ifid_hold, hc.idex_bubble} !== 3'b111) begin n_fail++; $display("FAIL halt_decode: got %b want 111", {hc.pc_hold, hc.ifid_hold, hc.idex_bubble}); end
    tick();
    hc.id_halt = 0;
    for (int e = 2; e <= 5; e++) begin
      #1;
      n_tests++; if (hc.pc_hold !== 1'b1) begin n_fail++; $display("FAIL halt_hold e%0d: got %b want 1", e, hc.pc_hold); end
      tick();
      n_tests++; if (hc.halted !== (e == 5)) begin n_fail++; $display("FAIL halt_edge e%0d: got %b want %b", e, hc.halted, (e == 5)); end
    end
    hc.ex_valid = 1; hc.ex_redirect = 1;
    #1;
    n_tests++; if ({hc.ifid_flush, hc.pc_hold} !== 2'b01) begin n_fail++; $display("FAIL halt_redirect_ignored: got %b want 01", {hc.ifid_flush, hc.pc_hold}); end
    tick();
    n_tests++; if (hc.halted !== 1'b1) begin n_fail++; $display("FAIL halt_stays: got %b want 1", hc.halted); end
    do_reset();
    n_tests++; if ({hc.halted, hc.pc_hold} !== 2'b00) begin n_fail++; $display("FAIL halt_reset: got %b want 00", {hc.halted, hc.pc_hold}); end
    $display("[TB] halt: halted=%b after reset", hc.halted);
  endtask

  task automatic test_drain_redirect();
    do_reset();
    hc.id_valid = 1; hc.id_halt = 1;
    tick();
    hc.id_halt = 0;
    tick();
    hc.ex_valid = 1; hc.ex_redirect = 1;
    #1;
    n_tests++; if ({hc.ifid_flush, hc.idex_bubble, hc.pc_hold} !== 3'b110) begin n_fail++; $display("FAIL dr_redirect: got %b want 110", {hc.ifid_flush, hc.idex_bubble, hc.pc_hold}); end
    tick();
    idle();
    #1;
    n_tests++; if (hc.pc_hold !== 1'b0) begin n_fail++; $display("FAIL dr_back_to_run: got %b want 0", hc.pc_hold); end
    for (int i = 0; i < 6; i++) tick();
    n_tests++; if (hc.halted !== 1'b0) begin n_fail++; $display("FAIL dr_never_halted: got %b want 0", hc.halted); end
    // Halt again, with a two-cycle memory wait inside the drain.
    hc.id_valid = 1; hc.id_halt = 1;
    tick();
    hc.id_valid = 0; hc.id_halt = 0; hc.mem_req = 1; hc.mem_ready = 0;
    tick(); tick();
    hc.mem_req = 0; hc.mem_ready = 1;
    tick(); tick(); tick();
    n_tests++; if (hc.halted !== 1'b0) begin n_fail++; $display("FAIL dr_wait_extends: got %b want 0", hc.halted); end
    tick();
    n_tests++; if (hc.halted !== 1'b1) begin n_fail++; $display("FAIL dr_wait_halted: got %b want 1", hc.halted); end
    do_reset();
    hc.id_valid = 1; hc.id_halt = 1;
    tick();
    do_reset();
    n_tests++; if (hc.pc_hold !== 1'b0) begin n_fail++; $display("FAIL dr_reset_abort: got %b want 0", hc.pc_hold); end
    $display("[TB] drain_redirect: halted=%b", hc.halted);
  endtask

  task automatic test_stall_saturate();
    do_reset();
    hc2.id_valid = 1; hc2.id_halt = 1;
    tick();
    hc2.id_halt = 0;
    for (int i = 1; i < 6; i++) tick();
    n_tests++; if (hc2.stall_cnt !== 3'd6) begin n_fail++; $display("FAIL sat_count: got %0d want 6", hc2.stall_cnt); end
    for (int i = 0; i < 6; i++) tick();
    n_tests++; if (hc2.stall_cnt !== 3'd7) begin n_fail++; $display("FAIL sat_hold: got %0d want 7", hc2.stall_cnt); end
    idle2();
    $display("[TB] stall_saturate: stall_cnt=%0d", hc2.stall_cnt);
  endtask

  initial begin
    idle();
    idle2();
    rst_n = 1'b0;
    tick();
    test_reset();
    test_load_use();
    test_fwd_priority();
    test_redirect_vs_load_use();
    test_memwait();
    test_halt();
    test_drain_redirect();
    test_stall_saturate();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
